// File: rtl/hilo_unit.sv
// hilo_unit: execute-stage multiply/divide unit holding the HI/LO registers.
//
// mult/multu/div/divu compute their result in the issue cycle, park it in a
// pending register, and commit it to HI/LO after a fixed latency (MULT_CYCLES
// or DIV_CYCLES). A down-counter times the latency and the commit happens on
// its terminal count. mthi/mtlo write HI/LO directly on the next edge.
//
// Ports:
//   clk     - clock, all state on rising edge
//   reset   - synchronous, active-high
//   A, B    - forwarded rs / rt operands
//   HILOop  - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 none
//   HILOwe  - HILOop valid this cycle
//   flush   - E-stage flush; suppresses any issue this cycle
//   start   - combinational: a mult/div issues this cycle
//   busy    - registered: mult/div in flight
//   HI, LO  - HI/LO register outputs
module hilo_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       HILOop,
  input  logic             HILOwe,
  input  logic             flush,
  output logic             start,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] pend_hi_q, pend_hi_d;
  logic [WIDTH-1:0] pend_lo_q, pend_lo_d;
  logic             pend_we_q, pend_we_d;
  logic             busy_q, busy_d;
  logic [CW-1:0]    count_q, count_d;

  logic                      issue;
  logic                      mt_ok;
  logic signed [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0]        prod_u;
  logic                      div_by_zero;
  logic                      div_ovf;
  logic [WIDTH-1:0]          div_b;
  logic signed [WIDTH-1:0]   quot_s, rem_s;
  logic [WIDTH-1:0]          quot_u, rem_u;
  logic [WIDTH-1:0]          res_hi, res_lo;
  logic                      res_we;

  assign issue = HILOwe && !flush && !busy_q && !HILOop[2];
  assign mt_ok = HILOwe && !flush && !busy_q;

  // Arithmetic datapath, evaluated every cycle; only captured on issue.
  always_comb begin
    prod_s = $signed({{WIDTH{A[WIDTH-1]}}, A}) * $signed({{WIDTH{B[WIDTH-1]}}, B});
    prod_u = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

    // Divisor is forced non-zero so the divider never sees x/0; the result
    // of a divide by zero is discarded at commit anyway.
    div_by_zero = (B == '0);
    div_b       = div_by_zero ? WIDTH'(1) : B;
    div_ovf     = (A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == '1);

    quot_s = $signed(A) / $signed(div_b);
    rem_s  = $signed(A) % $signed(div_b);
    if (div_ovf) begin
      // Most-negative / -1 wraps back to most-negative with zero remainder.
      quot_s = $signed(A);
      rem_s  = '0;
    end
    quot_u = A / div_b;
    rem_u  = A % div_b;

    res_hi = '0;
    res_lo = '0;
    case (HILOop[1:0])
      2'd0: begin res_hi = prod_s[2*WIDTH-1:WIDTH]; res_lo = prod_s[WIDTH-1:0]; end
      2'd1: begin res_hi = prod_u[2*WIDTH-1:WIDTH]; res_lo = prod_u[WIDTH-1:0]; end
      2'd2: begin res_hi = rem_s;                   res_lo = quot_s;            end
      default: begin res_hi = rem_u;                res_lo = quot_u;            end
    endcase
    res_we = !(HILOop[1] && div_by_zero);
  end

  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_we_d = pend_we_q;
    busy_d    = busy_q;
    count_d   = count_q;

    if (busy_q) begin
      // Anything presented while busy is dropped, including a coincident
      // mthi/mtlo on the commit edge.
      if (count_q == CW'(1)) begin
        busy_d  = 1'b0;
        count_d = '0;
        if (pend_we_q) begin
          hi_d = pend_hi_q;
          lo_d = pend_lo_q;
        end
      end else begin
        count_d = count_q - CW'(1);
      end
    end else if (issue) begin
      busy_d    = 1'b1;
      count_d   = HILOop[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      pend_hi_d = res_hi;
      pend_lo_d = res_lo;
      pend_we_d = res_we;
    end else if (mt_ok) begin
      if (HILOop == OP_MTHI) hi_d = A;
      if (HILOop == OP_MTLO) lo_d = A;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_we_q <= 1'b0;
      busy_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_we_q <= pend_we_d;
      busy_q    <= busy_d;
      count_q   <= count_d;
    end
  end

  assign start = issue;
  assign busy  = busy_q;
  assign HI    = hi_q;
  assign LO    = lo_q;

endmodule

// File: tb/tb_hilo_unit.sv
module tb_hilo_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_NONE  = 3'd7;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B;
  logic [2:0]  HILOop;
  logic        HILOwe;
  logic        flush;
  logic        start;
  logic        busy;
  logic [31:0] HI, LO;

  hilo_unit #(.WIDTH(32), .MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .HILOop(HILOop), .HILOwe(HILOwe),
    .flush(flush), .start(start), .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: architectural HI/LO plus the edge number at which the
  // in-flight result lands. busy is simply "current edge < done_edge".
  int          edge_n    = 0;
  int          done_edge = 0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [31:0] m_pend_hi = '0, m_pend_lo = '0;
  logic        m_pend_valid = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            output logic valid, output logic [31:0] hi, output logic [31:0] lo);
    longint      sa, sb, ma, mb, q, r;
    logic [63:0] p;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    valid = 1'b1;
    hi = '0;
    lo = '0;
    case (op)
      OP_MULT:  begin p = 64'(sa * sb);                        hi = p[63:32]; lo = p[31:0]; end
      OP_MULTU: begin p = 64'({32'b0, a}) * 64'({32'b0, b});   hi = p[63:32]; lo = p[31:0]; end
      OP_DIV: begin
        if (b == 0) valid = 1'b0;
        else begin
          ma = (sa < 0) ? -sa : sa;
          mb = (sb < 0) ? -sb : sb;
          q  = ma / mb;
          r  = ma % mb;
          if ((sa < 0) != (sb < 0)) q = -q;
          if (sa < 0) r = -r;
          lo = q[31:0];
          hi = r[31:0];
        end
      end
      default: begin
        if (b == 0) valid = 1'b0;
        else begin
          lo = a / b;
          hi = a % b;
        end
      end
    endcase
  endtask

  task automatic step(input logic [2:0] op, input logic we, input logic fl,
                      input logic [31:0] a, input logic [31:0] b);
    logic        busy_before, issue_exp, v;
    logic [31:0] rh, rl;
    @(negedge clk);
    reset = 1'b0; HILOop = op; HILOwe = we; flush = fl; A = a; B = b;
    #1;
    busy_before = (edge_n < done_edge);
    issue_exp   = we && !fl && !busy_before && (op <= OP_DIVU);
    chk("start", {31'b0, start}, {31'b0, issue_exp});
    @(posedge clk);
    edge_n++;
    if (edge_n == done_edge && m_pend_valid) begin
      m_hi = m_pend_hi;
      m_lo = m_pend_lo;
    end
    if (issue_exp) begin
      ref_result(op, a, b, v, rh, rl);
      m_pend_valid = v; m_pend_hi = rh; m_pend_lo = rl;
      done_edge = edge_n + ((op >= OP_DIV) ? DIV_N : MULT_N);
    end else if (we && !fl && !busy_before) begin
      if (op == OP_MTHI) m_hi = a;
      if (op == OP_MTLO) m_lo = a;
    end
    #1;
    chk("busy", {31'b0, busy}, {31'b0, (edge_n < done_edge)});
    chk("hi", HI, m_hi);
    chk("lo", LO, m_lo);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(OP_NONE, 1'b0, 1'b0, $urandom, $urandom);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; HILOwe = 1'b0; HILOop = OP_NONE; flush = 1'b0; A = $urandom; B = $urandom;
    #1;
    chk("start_in_reset", {31'b0, start}, 32'd0);
    @(posedge clk);
    edge_n++;
    m_hi = '0; m_lo = '0; m_pend_valid = 1'b0; done_edge = edge_n;
    #1;
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_hi", HI, 32'd0);
    chk("reset_lo", LO, 32'd0);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] ra, rb;
    reset = 1'b1; A = '0; B = '0; HILOop = OP_NONE; HILOwe = 1'b0; flush = 1'b0;

    do_reset();

    // mthi / mtlo
    step(OP_MTHI, 1'b1, 1'b0, 32'h12345678, 32'h0);
    chk("mthi_hi", HI, 32'h12345678);
    step(OP_MTLO, 1'b1, 1'b0, 32'h9ABCDEF0, 32'h0);
    chk("mtlo_hi", HI, 32'h12345678);
    chk("mtlo_lo", LO, 32'h9ABCDEF0);

    // MULT -3 * 7, old HI/LO held during busy (model checks every cycle)
    step(OP_MULT, 1'b1, 1'b0, 32'hFFFFFFFD, 32'd7);
    idle(MULT_N - 1);
    chk("mult_hold_lo", LO, 32'h9ABCDEF0);
    idle(1);
    chk("mult_hi", HI, 32'hFFFFFFFF);
    chk("mult_lo", LO, 32'hFFFFFFEB);

    step(OP_MULTU, 1'b1, 1'b0, 32'hFFFFFFFD, 32'd7);
    idle(MULT_N);
    chk("multu_hi", HI, 32'h00000006);
    chk("multu_lo", LO, 32'hFFFFFFEB);

    step(OP_DIV, 1'b1, 1'b0, 32'hFFFFFFF9, 32'd2);
    idle(DIV_N);
    chk("div_lo", LO, 32'hFFFFFFFD);
    chk("div_hi", HI, 32'hFFFFFFFF);

    step(OP_DIVU, 1'b1, 1'b0, 32'd7, 32'd0);
    idle(DIV_N - 1);
    chk("divz_busy_last", {31'b0, busy}, 32'd1);
    idle(1);
    chk("divz_busy_done", {31'b0, busy}, 32'd0);
    chk("divz_lo", LO, 32'hFFFFFFFD);
    chk("divz_hi", HI, 32'hFFFFFFFF);

    // ops presented while busy are dropped
    step(OP_DIV, 1'b1, 1'b0, 32'd100, 32'd7);
    step(OP_MTLO, 1'b1, 1'b0, 32'h55, 32'h0);
    step(OP_MULT, 1'b1, 1'b0, 32'd3, 32'd4);
    idle(DIV_N - 2);
    chk("busy_ops_lo", LO, 32'd14);
    chk("busy_ops_hi", HI, 32'd2);

    // flushed issue
    step(OP_DIV, 1'b1, 1'b1, 32'd9, 32'd3);
    chk("flush_busy", {31'b0, busy}, 32'd0);

    // overflow corner
    step(OP_DIV, 1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF);
    idle(DIV_N);
    chk("ovf_lo", LO, 32'h80000000);
    chk("ovf_hi", HI, 32'h00000000);

    // reset in the middle of a MULT
    step(OP_MTHI, 1'b1, 1'b0, 32'hAAAA5555, 32'h0);
    step(OP_MULT, 1'b1, 1'b0, 32'd5, 32'd6);
    idle(2);
    do_reset();
    idle(MULT_N + 1);
    chk("abort_hi", HI, 32'd0);
    chk("abort_lo", LO, 32'd0);

    // back-to-back MULT right after busy drops
    step(OP_MULT, 1'b1, 1'b0, 32'd11, 32'd13);
    idle(MULT_N);
    step(OP_MULT, 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("b2b_busy", {31'b0, busy}, 32'd1);
    chk("b2b_lo_first", LO, 32'd143);
    idle(MULT_N);
    chk("b2b_lo", LO, 32'd1);

    // randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        op = 3'($urandom_range(0, 7));
        ra = $urandom;
        rb = $urandom;
        case ($urandom_range(0, 7))
          0: rb = 32'd0;
          1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
          2: rb = 32'($urandom_range(1, 9));
          3: rb = -32'($urandom_range(1, 9));
          default: ;
        endcase
        step(op, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, ra, rb);
      end
    end
    idle(DIV_N + 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
- Execute-stage multiply/divide unit with HI/LO registers.
- Consumes the HILOop/HILOwe pair produced by the E-stage control decoder, plus the forwarded rs/rt operands.
- Executes mult/multu/div/divu with fixed multi-cycle latency and mthi/mtlo with single-cycle latency.
- Exposes HI/LO and start/busy to the hazard unit so it can stall the next HI/LO-touching instruction.

Parameters:
WIDTH, 32, operand and HI/LO width
MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high
A  input  WIDTH  rs operand (forwarded)
B  input  WIDTH  rt operand (forwarded)
HILOop  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO 7=none (6 reserved, treated as none)
HILOwe  input  1  HILOop is valid this cycle
flush  input  1  exception/eret flush of E stage; suppresses any issue this cycle
start  output  1  combinational: a mult/div issues this cycle
busy  output  1  registered: mult/div in flight
HI  output  WIDTH  HI register
LO  output  WIDTH  LO register

Behaviour:
- Reset: HI=0, LO=0, busy=0, cycle counter=0, pending result=0. Reset mid-operation aborts the op; no commit occurs.
- Issue condition:
  - issue = HILOwe && !flush && !busy && HILOop in {0..3}.
  - start = issue (combinational, no register).
- On an issue edge:
  - Compute the result from A/B as sampled that cycle and store it in the pending HI/LO registers.
  - busy<=1.
  - count <= MULT_CYCLES or DIV_CYCLES.
- While busy, each edge decrements count. On the edge where count==1: HI/LO <= pending, busy<=0, count<=0.
  - Net effect: a result issued at edge t is visible on HI/LO after edge t+N (N = latency). busy is high for exactly N cycles.
- mthi/mtlo:
  - Condition: HILOwe && !flush && !busy.
  - Action: HI<=A (MTHI) or LO<=A (MTLO) on the next edge. The other register is unchanged.
- Any HILOwe op arriving while busy is ignored: no state change, no queueing. The hazard unit guarantees stall, but the block must be safe.
- If a commit edge and a would-be mthi/mtlo coincide, the mthi/mtlo is ignored (busy still 1 that cycle), so only the commit occurs.
- flush affects only the issue cycle. An op already in flight completes and commits.
- Arithmetic:
  - MULT: signed 32x32->64; HI=product[63:32], LO=product[31:0].
  - MULTU: same, unsigned.
  - DIV: signed; LO=quotient truncated toward zero, HI=remainder with the sign of the dividend A.
  - DIVU: unsigned quotient/remainder.
  - Divide by zero (B==0): the op still occupies DIV_CYCLES busy cycles, but HI/LO stay unchanged at commit.
  - Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No trap.
- HI/LO outputs are direct register outputs. No bypass of pending or same-cycle writes.

Test Plan:
- Reset, then MTHI with A=0x12345678 and MTLO with A=0x9ABCDEF0 on consecutive cycles -> HI=0x12345678, LO=0x9ABCDEF0 one edge after each; busy stays 0, start stays 0.
- MULT A=0xFFFFFFFD (-3), B=7 -> start=1 in the issue cycle; busy=1 for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFEB. HI/LO hold their old values during busy.
- MULTU with the same operands -> after 5 cycles HI=0x00000006, LO=0xFFFFFFEB.
- DIV A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=0 -> busy 10 cycles; HI/LO unchanged.
- During a DIV: MTLO (A=0x55) and a second MULT presented while busy -> both ignored, start=0. A DIV issued with flush=1 -> no start, busy stays 0.
- Reset asserted 3 cycles into a MULT -> next cycle busy=0 and HI=LO=0, and the result never commits. Back-to-back MULT issued the cycle after busy falls -> accepted.
